// File: rtl/fir_pkg.sv
// Shared types and width helpers for the multi-channel moving-average FIR.
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        DONE
    } fir_state_t;

    // Running sum of 2^log2_n samples needs log2_n guard bits to never overflow.
    function automatic int unsigned sum_w(input int unsigned data_w, input int unsigned log2_n);
        return data_w + log2_n;
    endfunction

endpackage

// File: rtl/fir_history_buf.sv
// Per-channel circular sample history: asynchronous read and synchronous write at the same index.
module fir_history_buf #(
    parameter int unsigned DATA_W = 24,
    parameter int unsigned LOG2_N = 3
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [LOG2_N-1:0] ptr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int unsigned N = 1 << LOG2_N;

    logic [DATA_W-1:0] mem_q [N];

    // No reset: stale contents are masked by the fill count in the top.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[ptr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[ptr_i];

endmodule

// File: rtl/moving_avg_fir.sv
// Multi-channel 2^LOG2_N-tap boxcar filter with one adder time-shared across channels.
module moving_avg_fir
    import fir_pkg::*;
#(
    parameter int unsigned DATA_W   = 24,
    parameter int unsigned LOG2_N   = 3,
    parameter int unsigned CHANNELS = 2
) (
    input  logic                       CLOCK_50,
    input  logic                       reset_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [CHANNELS*DATA_W-1:0] in_data,
    input  logic                       bypass,
    input  logic                       clear,
    output logic                       out_valid,
    output logic [CHANNELS*DATA_W-1:0] out_data
);

    localparam int unsigned SUM_W  = sum_w(DATA_W, LOG2_N);
    localparam int unsigned N      = 1 << LOG2_N;
    localparam int unsigned CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int unsigned FILL_W = LOG2_N + 1;

    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(N);
    localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(CHANNELS - 1);

    fir_state_t                 state_q, state_d;
    logic [CH_W-1:0]            ch_q, ch_d;
    logic [LOG2_N-1:0]          ptr_q, ptr_d;
    logic [FILL_W-1:0]          fill_q, fill_d;
    logic                       bypass_q, bypass_d;
    logic [DATA_W-1:0]          new_q [CHANNELS];
    logic [DATA_W-1:0]          new_d [CHANNELS];
    logic signed [SUM_W-1:0]    sum_q [CHANNELS];
    logic signed [SUM_W-1:0]    sum_d [CHANNELS];
    logic [CHANNELS*DATA_W-1:0] out_q, out_d;

    logic [DATA_W-1:0]          hist_rd [CHANNELS];
    logic [CHANNELS-1:0]        hist_we;
    logic [DATA_W-1:0]          avg [CHANNELS];

    logic                       full;
    logic [DATA_W-1:0]          cur_new, cur_old;
    logic signed [SUM_W-1:0]    sum_nxt;

    assign full = (fill_q == FILL_FULL);

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        assign hist_we[k] = (state_q == ACC) && (ch_q == CH_W'(k)) && !clear;

        fir_history_buf #(
            .DATA_W(DATA_W),
            .LOG2_N(LOG2_N)
        ) u_buf (
            .clk_i  (CLOCK_50),
            .we_i   (hist_we[k]),
            .ptr_i  (ptr_q),
            .wdata_i(new_q[k]),
            .rdata_o(hist_rd[k])
        );

        // Arithmetic shift floors toward -inf; the quotient always fits DATA_W.
        assign avg[k] = DATA_W'(sum_q[k] >>> LOG2_N);
    end

    // Shared adder: the channel selected by ch_q retires its oldest sample.
    assign cur_new = new_q[ch_q];
    assign cur_old = full ? hist_rd[ch_q] : '0;
    assign sum_nxt = sum_q[ch_q]
                   + $signed({{LOG2_N{cur_new[DATA_W-1]}}, cur_new})
                   - $signed({{LOG2_N{cur_old[DATA_W-1]}}, cur_old});

    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        ptr_d     = ptr_q;
        fill_d    = fill_q;
        bypass_d  = bypass_q;
        new_d     = new_q;
        sum_d     = sum_q;
        out_d     = out_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;

        if (clear) begin
            state_d = IDLE;
            ch_d    = '0;
            ptr_d   = '0;
            fill_d  = '0;
            for (int k = 0; k < CHANNELS; k++) begin
                sum_d[k] = '0;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        for (int k = 0; k < CHANNELS; k++) begin
                            new_d[k] = in_data[k*DATA_W +: DATA_W];
                        end
                        bypass_d = bypass;
                        ch_d     = '0;
                        state_d  = ACC;
                    end
                end
                ACC: begin
                    sum_d[ch_q] = sum_nxt;
                    if (ch_q == CH_LAST) begin
                        state_d = DONE;
                    end else begin
                        ch_d = ch_q + 1'b1;
                    end
                end
                DONE: begin
                    out_valid = 1'b1;
                    for (int k = 0; k < CHANNELS; k++) begin
                        out_d[k*DATA_W +: DATA_W] = bypass_q ? new_q[k] : avg[k];
                    end
                    ptr_d = ptr_q + 1'b1;
                    if (!full) begin
                        fill_d = fill_q + 1'b1;
                    end
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            ch_q     <= '0;
            ptr_q    <= '0;
            fill_q   <= '0;
            bypass_q <= 1'b0;
            out_q    <= '0;
            for (int k = 0; k < CHANNELS; k++) begin
                new_q[k] <= '0;
                sum_q[k] <= '0;
            end
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            ptr_q    <= ptr_d;
            fill_q   <= fill_d;
            bypass_q <= bypass_d;
            out_q    <= out_d;
            for (int k = 0; k < CHANNELS; k++) begin
                new_q[k] <= new_d[k];
                sum_q[k] <= sum_d[k];
            end
        end
    end

    assign out_data = out_q;

endmodule
